// File: rtl/knap_pkg.sv
// Shared definitions for the knapsack loader and DP engine: sync byte, loader
// states, error codes and default problem limits.
package knap_pkg;

   localparam logic [7:0] SYNC_BYTE    = 8'hA5;
   localparam int         DEF_MAX_ITEM = 16;
   localparam int         DEF_MAX_CAP  = 64;

   typedef enum logic [2:0] {
      LD_IDLE,
      LD_HDR_N,
      LD_HDR_CAP,
      LD_ITEM_W,
      LD_ITEM_VH,
      LD_ITEM_VL,
      LD_CSUM
   } loader_state_e;

   localparam logic [1:0] ERR_NONE    = 2'd0;
   localparam logic [1:0] ERR_HDR     = 2'd1;
   localparam logic [1:0] ERR_CSUM    = 2'd2;
   localparam logic [1:0] ERR_TIMEOUT = 2'd3;

endpackage

// File: rtl/knap_item_loader_if.sv
// Byte-stream input, table read port and status of the knapsack item loader.
// slave = loader side, master = UART/DP side.
interface knap_item_loader_if #(
   parameter int MAX_ITEM = 16,
   parameter int DATA_W   = 32
) ();

   logic                        rx_valid;
   logic [7:0]                  rx_byte;
   logic                        clear;
   logic [$clog2(MAX_ITEM)-1:0] rd_idx;
   logic [DATA_W-1:0]           rd_weight;
   logic [DATA_W-1:0]           rd_value;
   logic [DATA_W-1:0]           item_num;
   logic [DATA_W-1:0]           cap;
   logic                        table_valid;
   logic                        load_done;
   logic                        err;
   logic [1:0]                  err_code;

   modport slave (
      input  rx_valid, rx_byte, clear, rd_idx,
      output rd_weight, rd_value, item_num, cap, table_valid, load_done, err, err_code
   );

   modport master (
      output rx_valid, rx_byte, clear, rd_idx,
      input  rd_weight, rd_value, item_num, cap, table_valid, load_done, err, err_code
   );

endinterface

// File: rtl/knap_item_ram.sv
// Item table: DEPTH x {weight[7:0], value[15:0]}, one write port and one
// registered read port (read data cleared by reset, storage is not).
module knap_item_ram #(
   parameter int DEPTH = 16,
   parameter int IDX_W = 4
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             we,
   input  logic [IDX_W-1:0] wr_idx,
   input  logic [7:0]       wr_weight,
   input  logic [15:0]      wr_value,
   input  logic [IDX_W-1:0] rd_idx,
   output logic [7:0]       rd_weight,
   output logic [15:0]      rd_value
);

   logic [23:0] mem_q [DEPTH];
   logic [23:0] rd_data_d, rd_data_q;

   always_ff @(posedge clk) begin
      if (we) mem_q[wr_idx] <= {wr_weight, wr_value};
   end

   always_comb begin
      rd_data_d = mem_q[rd_idx];
   end

   always_ff @(posedge clk) begin
      if (reset) rd_data_q <= '0;
      else       rd_data_q <= rd_data_d;
   end

   assign rd_weight = rd_data_q[23:16];
   assign rd_value  = rd_data_q[15:0];

endmodule

// File: rtl/knap_item_loader.sv
// Parses the UART byte stream into the knapsack item table; table_valid only
// after a checksum-clean packet. Optional inter-byte timeout: LOADER_TIMEOUT_EN.
module knap_item_loader
   import knap_pkg::*;
#(
   parameter int MAX_ITEM    = DEF_MAX_ITEM,
   parameter int MAX_CAP     = DEF_MAX_CAP,
   parameter int DATA_W      = 32,
   parameter int TIMEOUT_CYC = 1_000_000
) (
   input logic               clk,
   input logic               reset,
   knap_item_loader_if.slave bus
);

   localparam int         IDX_W   = $clog2(MAX_ITEM);
   localparam logic [7:0] MAX_N_B = 8'(MAX_ITEM);
   localparam logic [7:0] MAX_C_B = 8'(MAX_CAP);

   loader_state_e state_q, state_d;
   logic [7:0]    n_q, n_d, c_q, c_d, cnt_q, cnt_d, csum_q, csum_d;
   logic [7:0]    w_q, w_d, vh_q, vh_d;
   logic [7:0]    item_num_q, item_num_d, cap_q, cap_d;
   logic          table_valid_q, table_valid_d;
   logic          load_done_q, load_done_d;
   logic          err_q, err_d;
   logic [1:0]    err_code_q, err_code_d;
   logic          ram_we;
   logic [7:0]    ram_rd_w;
   logic [15:0]   ram_rd_v;
   logic [7:0]    b;

   assign b = bus.rx_byte;

`ifdef LOADER_TIMEOUT_EN
   localparam int TMO_W = $clog2(TIMEOUT_CYC + 1);
   logic [TMO_W-1:0] tmo_q, tmo_d;
   logic             tmo_hit;

   assign tmo_hit = (state_q != LD_IDLE) && (tmo_q == TMO_W'(TIMEOUT_CYC - 1));
`endif

   always_comb begin
      state_d       = state_q;
      n_d           = n_q;
      c_d           = c_q;
      cnt_d         = cnt_q;
      csum_d        = csum_q;
      w_d           = w_q;
      vh_d          = vh_q;
      item_num_d    = item_num_q;
      cap_d         = cap_q;
      table_valid_d = table_valid_q;
      err_code_d    = err_code_q;
      load_done_d   = 1'b0;
      err_d         = 1'b0;
      ram_we        = 1'b0;
`ifdef LOADER_TIMEOUT_EN
      tmo_d = (state_q == LD_IDLE || bus.rx_valid || bus.clear) ? '0 : tmo_q + 1'b1;
`endif
      // clear beats a same-cycle byte and never raises err
      if (bus.clear) begin
         state_d       = LD_IDLE;
         table_valid_d = 1'b0;
      end else if (bus.rx_valid) begin
         case (state_q)
            LD_IDLE: begin
               if (b == SYNC_BYTE) begin
                  state_d       = LD_HDR_N;
                  table_valid_d = 1'b0;
                  err_code_d    = ERR_NONE;
                  csum_d        = '0;
               end
            end
            LD_HDR_N: begin
               csum_d = csum_q ^ b;
               n_d    = b;
               cnt_d  = '0;
               if (b == 8'd0 || b > MAX_N_B) begin
                  err_d      = 1'b1;
                  err_code_d = ERR_HDR;
                  state_d    = LD_IDLE;
               end else begin
                  state_d = LD_HDR_CAP;
               end
            end
            LD_HDR_CAP: begin
               csum_d = csum_q ^ b;
               c_d    = b;
               if (b == 8'd0 || b > MAX_C_B) begin
                  err_d      = 1'b1;
                  err_code_d = ERR_HDR;
                  state_d    = LD_IDLE;
               end else begin
                  state_d = LD_ITEM_W;
               end
            end
            LD_ITEM_W: begin
               csum_d  = csum_q ^ b;
               w_d     = b;
               state_d = LD_ITEM_VH;
            end
            LD_ITEM_VH: begin
               csum_d  = csum_q ^ b;
               vh_d    = b;
               state_d = LD_ITEM_VL;
            end
            LD_ITEM_VL: begin
               csum_d  = csum_q ^ b;
               ram_we  = 1'b1;
               cnt_d   = cnt_q + 8'd1;
               state_d = (cnt_q + 8'd1 == n_q) ? LD_CSUM : LD_ITEM_W;
            end
            LD_CSUM: begin
               state_d = LD_IDLE;
               if (b == csum_q) begin
                  item_num_d    = n_q;
                  cap_d         = c_q;
                  table_valid_d = 1'b1;
                  load_done_d   = 1'b1;
               end else begin
                  err_d      = 1'b1;
                  err_code_d = ERR_CSUM;
               end
            end
            default: state_d = LD_IDLE;
         endcase
`ifdef LOADER_TIMEOUT_EN
      end else if (tmo_hit) begin
         err_d      = 1'b1;
         err_code_d = ERR_TIMEOUT;
         state_d    = LD_IDLE;
`endif
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q       <= LD_IDLE;
         n_q           <= '0;
         c_q           <= '0;
         cnt_q         <= '0;
         csum_q        <= '0;
         w_q           <= '0;
         vh_q          <= '0;
         item_num_q    <= '0;
         cap_q         <= '0;
         table_valid_q <= 1'b0;
         load_done_q   <= 1'b0;
         err_q         <= 1'b0;
         err_code_q    <= ERR_NONE;
      end else begin
         state_q       <= state_d;
         n_q           <= n_d;
         c_q           <= c_d;
         cnt_q         <= cnt_d;
         csum_q        <= csum_d;
         w_q           <= w_d;
         vh_q          <= vh_d;
         item_num_q    <= item_num_d;
         cap_q         <= cap_d;
         table_valid_q <= table_valid_d;
         load_done_q   <= load_done_d;
         err_q         <= err_d;
         err_code_q    <= err_code_d;
      end
   end

`ifdef LOADER_TIMEOUT_EN
   always_ff @(posedge clk) begin
      if (reset) tmo_q <= '0;
      else       tmo_q <= tmo_d;
   end
`endif

   knap_item_ram #(
      .DEPTH (MAX_ITEM),
      .IDX_W (IDX_W)
   ) u_ram (
      .clk       (clk),
      .reset     (reset),
      .we        (ram_we),
      .wr_idx    (cnt_q[IDX_W-1:0]),
      .wr_weight (w_q),
      .wr_value  ({vh_q, b}),
      .rd_idx    (bus.rd_idx),
      .rd_weight (ram_rd_w),
      .rd_value  (ram_rd_v)
   );

   assign bus.rd_weight   = DATA_W'(ram_rd_w);
   assign bus.rd_value    = DATA_W'(ram_rd_v);
   assign bus.item_num    = DATA_W'(item_num_q);
   assign bus.cap         = DATA_W'(cap_q);
   assign bus.table_valid = table_valid_q;
   assign bus.load_done   = load_done_q;
   assign bus.err         = err_q;
   assign bus.err_code    = err_code_q;

endmodule
